path_metric_select: RTL and testbench

Parametrised survivor selector for the turbo/Viterbi decode datapath. It accepts a stream of N_PATH candidate path metrics per frame, one per cycle, and tracks the best metric (minimum or maximum, chosen per frame) and the second-best metric. It emits the winning path index, the winning metric and the reliability delta (the absolute difference between best and second-best) for downstream soft-output logic. It replaces fixed 16-path sequential comparators and supports back-to-back frames with no idle cycles.

---
 rtl/path_metric_select.sv | 149 ++++++++++++++
 tb/tb_path_metric_select.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/path_metric_select.sv
// Streaming survivor selector: tracks best and second-best path metric per frame
// (min or max mode) and reports winner index, winner metric and reliability delta.
module path_metric_select #(
    parameter int MW     = 30,
    parameter int N_PATH = 16,
    localparam int IW    = $clog2(N_PATH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [MW-1:0] in_metric,
    input  logic          in_last,
    input  logic          sel_max,
    output logic          out_valid,
    output logic [IW-1:0] best_idx,
    output logic [MW-1:0] best_metric,
    output logic [MW-1:0] delta,
    output logic          frame_err
);

    localparam logic [IW-1:0] LAST_POS = IW'(N_PATH - 1);

    typedef enum logic {IDLE, ACC} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          mode_q, mode_d;
    logic          have2_q, have2_d;
    logic [MW-1:0] best_q, best_d;
    logic [MW-1:0] second_q, second_d;

    logic          out_valid_q, out_valid_d;
    logic [IW-1:0] best_idx_q, best_idx_d;
    logic [MW-1:0] best_metric_q, best_metric_d;
    logic [MW-1:0] delta_q, delta_d;
    logic          frame_err_q, frame_err_d;

    logic          close_frame;
    logic          len_err;

    function automatic logic better(input logic [MW-1:0] a, input logic [MW-1:0] b,
                                    input logic max_mode);
        return max_mode ? (a > b) : (a < b);
    endfunction

    // Best is never worse than second, so ordering the subtraction by mode cannot wrap.
    function automatic logic [MW-1:0] abs_delta(input logic [MW-1:0] b, input logic [MW-1:0] s,
                                                input logic max_mode, input logic have_second);
        if (!have_second) return '1;
        return max_mode ? (b - s) : (s - b);
    endfunction

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        mode_d        = mode_q;
        have2_d       = have2_q;
        best_d        = best_q;
        second_d      = second_q;
        close_frame   = 1'b0;
        len_err       = 1'b0;
        out_valid_d   = 1'b0;
        best_idx_d    = best_idx_q;
        best_metric_d = best_metric_q;
        delta_d       = delta_q;
        frame_err_d   = frame_err_q;

        if (in_valid) begin
            if (state_q == IDLE) begin
                mode_d  = sel_max;
                best_d  = in_metric;
                idx_d   = '0;
                have2_d = 1'b0;
                cnt_d   = IW'(1);
                if (in_last) begin
                    close_frame = 1'b1;
                    len_err     = 1'b1;
                end else begin
                    state_d = ACC;
                end
            end else begin
                if (better(in_metric, best_q, mode_q)) begin
                    second_d = best_q;
                    have2_d  = 1'b1;
                    best_d   = in_metric;
                    idx_d    = cnt_q;
                end else if (!have2_q || better(in_metric, second_q, mode_q) ||
                             (in_metric == second_q)) begin
                    second_d = in_metric;
                    have2_d  = 1'b1;
                end
                cnt_d = cnt_q + 1'b1;
                if (in_last || (cnt_q == LAST_POS)) begin
                    close_frame = 1'b1;
                    len_err     = !(in_last && (cnt_q == LAST_POS));
                end
            end
        end

        // Results are taken from the post-update values so latency stays at one clock.
        if (close_frame) begin
            state_d       = IDLE;
            cnt_d         = '0;
            out_valid_d   = 1'b1;
            best_idx_d    = idx_d;
            best_metric_d = best_d;
            delta_d       = abs_delta(best_d, second_d, mode_d, have2_d);
            frame_err_d   = len_err;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            out_valid_q   <= 1'b0;
            best_idx_q    <= '0;
            best_metric_q <= '0;
            delta_q       <= '0;
            frame_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            out_valid_q   <= out_valid_d;
            best_idx_q    <= best_idx_d;
            best_metric_q <= best_metric_d;
            delta_q       <= delta_d;
            frame_err_q   <= frame_err_d;
        end
    end

    // Frame-local tracking registers are always reloaded by the first sample of a frame.
    always_ff @(posedge clk) begin
        idx_q    <= idx_d;
        mode_q   <= mode_d;
        have2_q  <= have2_d;
        best_q   <= best_d;
        second_q <= second_d;
    end

    assign out_valid   = out_valid_q;
    assign best_idx    = best_idx_q;
    assign best_metric = best_metric_q;
    assign delta       = delta_q;
    assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_path_metric_select.sv
// Testbench for path_metric_select: table of frames driven back-to-back, expected
// results queued at the closing sample and compared when out_valid pulses.
module tb_path_metric_select;

    localparam int MW = 30;
    localparam int NP = 16;
    localparam int IW = $clog2(NP);
    localparam logic [MW-1:0] ONES = {MW{1'b1}};

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic [MW-1:0] in_metric = '0;
    logic          in_last = 1'b0;
    logic          sel_max = 1'b0;
    logic          out_valid;
    logic [IW-1:0] best_idx;
    logic [MW-1:0] best_metric;
    logic [MW-1:0] delta;
    logic          frame_err;

    path_metric_select #(.MW(MW), .N_PATH(NP)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_metric  (in_metric),
        .in_last    (in_last),
        .sel_max    (sel_max),
        .out_valid  (out_valid),
        .best_idx   (best_idx),
        .best_metric(best_metric),
        .delta      (delta),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            len;
        bit            last;
        bit            sel;
        bit            tog;
        bit            gap;
        int            base;
        int            step;
        int            p1;
        logic [MW-1:0] v1;
        int            p2;
        logic [MW-1:0] v2;
        int            c0;
        int            i0;
        logic [MW-1:0] m0;
        logic [MW-1:0] d0;
        bit            r0;
        int            c1;
        int            i1;
        logic [MW-1:0] m1;
        logic [MW-1:0] d1;
        bit            r1;
    } rec_t;

    typedef struct {
        int            cyc;
        int            idx;
        logic [MW-1:0] met;
        logic [MW-1:0] dlt;
        bit            err;
    } exp_t;

    rec_t tbl[11];
    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    bit   done = 0;

    task automatic check(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [MW-1:0] met(input rec_t r, input int i);
        if (i == r.p1) return r.v1;
        if (i == r.p2) return r.v2;
        return MW'(r.base + r.step * i);
    endfunction

    task automatic drive(input logic v, input logic [MW-1:0] m, input logic l, input logic s);
        in_valid  = v;
        in_metric = m;
        in_last   = l;
        sel_max   = s;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int idx, input logic [MW-1:0] m, input logic [MW-1:0] d,
                        input bit e);
        exp_t x;
        x.cyc = cyc;
        x.idx = idx;
        x.met = m;
        x.dlt = d;
        x.err = e;
        q.push_back(x);
    endtask

    task automatic send_frame(input rec_t r);
        for (int i = 0; i < r.len; i++) begin
            logic s;
            s = (i == 0) ? r.sel : (r.tog ? ~r.sel : r.sel);
            drive(1'b1, met(r, i), r.last && (i == r.len - 1), s);
            if (i == r.c0) push(r.i0, r.m0, r.d0, r.r0);
            if (i == r.c1) push(r.i1, r.m1, r.d1, r.r1);
            // Idle slot carries in_last=1 and metric 0 to prove both are qualified by in_valid.
            if (r.gap && (i % 2 == 1) && (i != r.len - 1)) drive(1'b0, '0, 1'b1, ~r.sel);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        //          len last sel tog gap base  step p1  v1     p2 v2   c0  i0  m0    d0          r0  c1  i1 m1 d1   r1
        tbl[0]  = '{16, 1, 0, 0, 0, 170, -10,  7, 5,     -1, 0,  15,  7, 5,    15,         0, -1, 0, 0, 0,   0};
        tbl[1]  = '{16, 1, 0, 0, 0, 50,    0,  3, 12,     9, 12, 15,  3, 12,   0,          0, -1, 0, 0, 0,   0};
        tbl[2]  = '{16, 1, 1, 1, 0, 7,     0, 15, ONES,  -1, 0,  15, 15, ONES, ONES - 7,   0, -1, 0, 0, 0,   0};
        tbl[3]  = '{16, 1, 1, 0, 0, 1000, -1, -1, 0,     -1, 0,  15,  0, 1000, 1,          0, -1, 0, 0, 0,   0};
        tbl[4]  = '{16, 1, 0, 0, 0, 500,   3, 14, 2,     -1, 0,  15, 14, 2,    498,        0, -1, 0, 0, 0,   0};
        tbl[5]  = '{16, 1, 0, 0, 1, 500,   3, 14, 2,     -1, 0,  15, 14, 2,    498,        0, -1, 0, 0, 0,   0};
        tbl[6]  = '{16, 1, 1, 0, 0, 10,    5, -1, 0,     -1, 0,  15, 15, 85,   5,          0, -1, 0, 0, 0,   0};
        tbl[7]  = '{1,  1, 0, 0, 0, 9,     0, -1, 0,     -1, 0,   0,  0, 9,    ONES,       1, -1, 0, 0, 0,   0};
        tbl[8]  = '{5,  1, 0, 0, 0, 40,   -3, -1, 0,     -1, 0,   4,  4, 28,   3,          1, -1, 0, 0, 0,   0};
        tbl[9]  = '{16, 1, 1, 0, 0, 100,   0,  5, 200,   11, 200, 15,  5, 200,  0,          0, -1, 0, 0, 0,   0};
        tbl[10] = '{20, 1, 0, 0, 0, 300,  -1, 18, 3,     -1, 0,  15, 15, 285,  1,          1, 19, 2, 3, 278, 1};

        repeat (2) @(negedge clk);
        check("reset out_valid", out_valid, 0);
        check("reset best_idx", best_idx, 0);
        check("reset best_metric", best_metric, 0);
        check("reset delta", delta, 0);
        check("reset frame_err", frame_err, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        fork
            begin
                for (int t = 0; t < 11; t++) send_frame(tbl[t]);

                // Mid-frame reset: eight samples in, then async reset with outputs holding a result.
                for (int i = 0; i < 8; i++) drive(1'b1, MW'(50), 1'b0, 1'b0);
                rst = 1'b0;
                in_valid = 1'b0;
                #1;
                check("async rst out_valid", out_valid, 0);
                check("async rst best_idx", best_idx, 0);
                check("async rst best_metric", best_metric, 0);
                check("async rst delta", delta, 0);
                check("async rst frame_err", frame_err, 0);
                repeat (2) @(posedge clk);
                #1;
                rst = 1'b1;
                send_frame(tbl[0]);

                repeat (3) drive(1'b0, '0, 1'b0, 1'b0);
                check("queue drained", q.size(), 0);
                done = 1;
            end
            begin
                while (!done) begin
                    @(negedge clk);
                    if (out_valid) begin
                        if (q.size() == 0) begin
                            check("spurious out_valid", 1, 0);
                        end else begin
                            exp_t e;
                            e = q.pop_front();
                            check("out_valid cycle", cyc, e.cyc);
                            check("best_idx", best_idx, e.idx);
                            check("best_metric", best_metric, e.met);
                            check("delta", delta, e.dlt);
                            check("frame_err", frame_err, e.err);
                        end
                    end else if (q.size() != 0 && q[0].cyc < cyc) begin
                        check("missing out_valid", 0, 1);
                        void'(q.pop_front());
                    end
                end
            end
        join

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
